cdc_hs_rx: RTL

Receive-side endpoint of a 4-phase request/acknowledge CDC bundle, in the destination clock domain. It synchronises an asynchronous request through a parametrised synchroniser chain and captures the sender-held data word. It presents the word to local logic on a valid/ready interface and returns a registered acknowledge to the source domain. It replaces a bare 2-flop request path with a complete, protocol-checked transfer engine that is safe for any clock ratio.

---
 rtl/cdc_hs_rx.sv | 132 +++++++++++++
 1 files changed

// File: rtl/cdc_hs_rx.sv
// Destination-side endpoint of a 4-phase req/ack CDC bundle: synchronises the
// request, captures the sender-held word, offers it on valid/ready and returns ack.
module cdc_hs_rx #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk_dest,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic                     in_req,
  output logic                     in_ack,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     err_proto,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("cdc_hs_rx: SYNC_STAGES must be 2 or more");
  end

  // state | meaning
  // IDLE  | no transfer; waiting for synchronised request
  // VALID | word captured and offered to the consumer; ack still low
  // ACK   | word consumed, ack high; waiting for the request to return to zero
  typedef enum logic [1:0] {S_IDLE, S_VALID, S_ACK} state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [SYNC_STAGES-1:0]   r_sync;
  logic                     w_req_s;
  logic                     r_err_seen;
  logic                     w_err_seen_nxt;
  logic                     r_ack;
  logic                     w_ack_nxt;
  logic                     r_valid;
  logic                     w_valid_nxt;
  logic                     r_err;
  logic                     w_err_nxt;
  logic                     w_capture;
  logic                     w_cnt_inc;
  logic [DATA_WIDTH-1:0]    r_data;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  assign w_req_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_dest) begin
    if (rst) begin
      r_sync     <= '0;
      r_state    <= S_IDLE;
      r_err_seen <= 1'b0;
      r_ack      <= 1'b0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_data     <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], in_req};
      r_state    <= w_state_nxt;
      r_err_seen <= w_err_seen_nxt;
      r_ack      <= w_ack_nxt;
      r_valid    <= w_valid_nxt;
      r_err      <= w_err_nxt;
      if (w_capture) begin
        r_data <= in_data;
      end
      if (w_cnt_inc && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
      end
    end
  end

  // A withdrawn request is flagged once per transfer; the word is still delivered
  // but never acknowledged, even if the request reappears before consumption.
  always_comb begin
    w_state_nxt    = r_state;
    w_err_seen_nxt = r_err_seen;
    w_ack_nxt      = r_ack;
    w_valid_nxt    = r_valid;
    w_err_nxt      = 1'b0;
    w_capture      = 1'b0;
    w_cnt_inc      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req_s) begin
          w_capture      = 1'b1;
          w_valid_nxt    = 1'b1;
          w_err_seen_nxt = 1'b0;
          w_state_nxt    = S_VALID;
        end
      end
      S_VALID: begin
        if (!w_req_s && !r_err_seen) begin
          w_err_nxt      = 1'b1;
          w_cnt_inc      = 1'b1;
          w_err_seen_nxt = 1'b1;
        end
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          if (w_req_s && !r_err_seen) begin
            w_ack_nxt   = 1'b1;
            w_state_nxt = S_ACK;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_ACK: begin
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ack_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign in_ack    = r_ack;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign err_proto = r_err;
  assign err_cnt   = r_err_cnt;
  assign busy      = (r_state != S_IDLE);

endmodule
